// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared constants, state encoding and small helpers for the 16-channel
// round-robin mux scheduler.
package mux16_rr_scheduler_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [N_CH-1:0] onehot16(input logic [SEL_W-1:0] idx);
    return {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// Combinational round-robin picker: first set bit of eff searching from
// ptr upward with wrap-around.
module rr_pick16
  import mux16_rr_scheduler_pkg::*;
(
  input  logic [N_CH-1:0]  eff,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_CH-1:0] dbl_s;
  logic [N_CH-1:0]   rot_s;
  logic [SEL_W-1:0]  off_s;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    dbl_s = {eff, eff} >> ptr;
    rot_s = dbl_s[N_CH-1:0];
    off_s = {SEL_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SEL_W'(i);
      end else begin
        off_s = off_s;
      end
    end
    any = |eff;
    idx = off_s + ptr;
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing one 16:1 mux among 16 requesters, with a
// valid/ready handshake downstream and a per-grant timeout.
module mux16_rr_scheduler
  import mux16_rr_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  mask,
  input  logic             out_ready,
  output logic [SEL_W-1:0] select,
  output logic [N_CH-1:0]  grant,
  output logic             out_valid,
  output logic             done,
  output logic             timeout
);

  // Counter value in the last GRANT cycle before the grant is dropped.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}}
                                                         : CNT_W'(TIMEOUT - 1);
  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic [N_CH-1:0]  eff_s;
  logic             any_s;
  logic [SEL_W-1:0] win_s;

  assign eff_s = req & mask;

  rr_pick16 u_pick (
    .eff (eff_s),
    .ptr (ptr_q),
    .any (any_s),
    .idx (win_s)
  );

  // Next-state logic: arbitrate in IDLE, hold the grant until accept or timeout.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    select_d    = select_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          select_d    = win_s;
          grant_d     = onehot16(win_s);
          out_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = ST_GRANT;
        end else begin
          grant_d     = {N_CH{1'b0}};
          out_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        // Acceptance takes priority over a timeout landing in the same cycle.
        if (out_ready) begin
          done_d      = 1'b1;
          out_valid_d = 1'b0;
          grant_d     = {N_CH{1'b0}};
          ptr_d       = select_q + SEL_ONE;
          state_d     = ST_IDLE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          timeout_d   = 1'b1;
          out_valid_d = 1'b0;
          grant_d     = {N_CH{1'b0}};
          ptr_d       = select_q + SEL_ONE;
          state_d     = ST_IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = {N_CH{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything without pulsing done/timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {SEL_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      select_q    <= {SEL_W{1'b0}};
      grant_q     <= {N_CH{1'b0}};
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      select_q    <= select_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign select    = select_q;
  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: reset, scripted vector table,
// rotation/wrap run and randomized traffic against a reference model.
module tb_mux16_rr_scheduler;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mask;
  logic        out_ready;
  logic [3:0]  select;
  logic [15:0] grant;
  logic        out_valid;
  logic        done;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  mux16_rr_scheduler #(.TIMEOUT(TMO), .CNT_W(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .out_ready (out_ready),
    .select    (select),
    .grant     (grant),
    .out_valid (out_valid),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] req;
    logic [15:0] mask;
    logic        rdy;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        done;
    logic        to;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] r, input logic [15:0] m, input logic rdy,
                              input logic [3:0] s, input logic [15:0] g,
                              input logic v, input logic d, input logic t);
    vec_t x;
    x.req = r; x.mask = m; x.rdy = rdy; x.sel = s; x.grant = g;
    x.valid = v; x.done = d; x.to = t;
    return x;
  endfunction

  vec_t tbl [26];

  // Reference model: a channel is "being served" for a number of cycles;
  // service ends on acceptance or after TMO cycles without it.
  bit m_busy;
  int m_sel, m_held, m_ptr;
  bit m_done, m_to;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_held = 0; m_ptr = 0; m_done = 0; m_to = 0;
  endtask

  task automatic model_edge();
    logic [15:0] eff;
    bit found;
    m_done = 0;
    m_to   = 0;
    if (m_busy) begin
      if (out_ready) begin
        m_done = 1; m_busy = 0; m_ptr = (m_sel + 1) % 16;
      end else if (TMO != 0 && m_held == TMO) begin
        m_to = 1; m_busy = 0; m_ptr = (m_sel + 1) % 16;
      end else begin
        m_held++;
      end
    end else begin
      eff = req & mask;
      found = 0;
      for (int k = 0; k < 16; k++) begin
        int c;
        c = (m_ptr + k) % 16;
        if (!found && eff[c]) begin
          found = 1; m_sel = c;
        end
      end
      if (found) begin
        m_busy = 1; m_held = 1;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    logic [15:0] g;
    g = m_busy ? (16'h0001 << m_sel) : 16'h0000;
    chk($sformatf("rnd%0d select", cyc), 32'(select), 32'(m_sel));
    chk($sformatf("rnd%0d grant", cyc), 32'(grant), 32'(g));
    chk($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(m_busy));
    chk($sformatf("rnd%0d done", cyc), 32'(done), 32'(m_done));
    chk($sformatf("rnd%0d timeout", cyc), 32'(timeout), 32'(m_to));
  endtask

  initial begin
    // Scripted table: single request, fairness, masking, timeout, simultaneous events.
    tbl[0]  = mk(16'h0020, 16'hFFFF, 1'b0, 4'd5,  16'h0020, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(16'h0020, 16'hFFFF, 1'b1, 4'd5,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(16'h8041, 16'hFFFF, 1'b0, 4'd6,  16'h0040, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(16'h8041, 16'hFFFF, 1'b1, 4'd6,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(16'h8041, 16'hFFFF, 1'b0, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(16'h8041, 16'hFFFF, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(16'h8041, 16'hFFFF, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(16'h8041, 16'hFFFF, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(16'h8041, 16'hFFFF, 1'b0, 4'd6,  16'h0040, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(16'h8041, 16'hFFFF, 1'b1, 4'd6,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(16'h8041, 16'h7FFF, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(16'h8041, 16'h7FFF, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(16'h8041, 16'h7FFF, 1'b0, 4'd6,  16'h0040, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(16'h8041, 16'h7FFF, 1'b1, 4'd6,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[14] = mk(16'h0000, 16'hFFFF, 1'b0, 4'd6,  16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(16'h0008, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(16'h0000, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk(16'h0000, 16'h0000, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[18] = mk(16'hFFFF, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[19] = mk(16'h0008, 16'hFFFF, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(16'h0008, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[21] = mk(16'h0008, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[22] = mk(16'h0008, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[23] = mk(16'h0008, 16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0);
    tbl[24] = mk(16'h0008, 16'hFFFF, 1'b1, 4'd3,  16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[25] = mk(16'h0000, 16'hFFFF, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset values.
    rst = 1'b1; req = 16'h0000; mask = 16'hFFFF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset select", 32'(select), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Reset asserted mid-GRANT with select=5.
    req = 16'h0020;
    @(posedge clk); #1;
    chk("pre-rst select", 32'(select), 32'd5);
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("async-rst select", 32'(select), 32'd0);
    chk("async-rst grant", 32'(grant), 32'd0);
    chk("async-rst out_valid", 32'(out_valid), 32'd0);
    chk("async-rst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("in-rst done", 32'(done), 32'd0);
    chk("in-rst timeout", 32'(timeout), 32'd0);
    rst = 1'b0; req = 16'h0000; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst%0d out_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("post-rst%0d done", i), 32'(done), 32'd0);
      chk($sformatf("post-rst%0d grant", i), 32'(grant), 32'd0);
    end

    // Table-driven scripted vectors.
    for (int i = 0; i < 26; i++) begin
      req = tbl[i].req; mask = tbl[i].mask; out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d select", i), 32'(select), 32'(tbl[i].sel));
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d timeout", i), 32'(timeout), 32'(tbl[i].to));
    end

    // Rotation and wrap: all channels requesting, consumer always ready.
    rst = 1'b1; req = 16'hFFFF; mask = 16'hFFFF; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int s;
      s = (i / 2) % 16;
      @(posedge clk); #1;
      chk($sformatf("rot%0d select", i), 32'(select), 32'(s));
      chk($sformatf("rot%0d out_valid", i), 32'(out_valid), 32'((i % 2) == 0));
      chk($sformatf("rot%0d done", i), 32'(done), 32'((i % 2) == 1));
      chk($sformatf("rot%0d grant", i), 32'(grant), ((i % 2) == 0) ? (32'd1 << s) : 32'd0);
    end

    // Randomized traffic against the reference model.
    rst = 1'b1; req = 16'h0000; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: req = 16'h0000;
        1: req = 16'($urandom);
        default: req = 16'($urandom & $urandom & $urandom);
      endcase
      mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      out_ready = ($urandom_range(0, 3) == 0);
      model_edge();
      @(posedge clk); #1;
      model_check(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Round-robin scheduler that shares one 16:1 selector datapath among 16 requesters.
- Produces the registered 4-bit select for the mux, a one-hot grant back to the requesters, and a valid/ready handshake toward the downstream consumer of the mux output.
- Includes a per-grant timeout so a stalled consumer cannot starve the other requesters.

Parameters:
- TIMEOUT, 16, max GRANT-state cycles without out_ready before the grant is dropped; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  16  request per mux input channel; bit i requests in[i].
- mask  input  16  channel enable; effective request is req & mask.
- out_ready  input  1  downstream accepts the current mux output this cycle.
- select  output  4  registered select driving the 16:1 mux.
- grant  output  16  registered one-hot grant; equals 1 << select while out_valid, otherwise 0.
- out_valid  output  1  mux output is valid for the granted channel.
- done  output  1  one-cycle pulse: transfer accepted (out_valid & out_ready).
- timeout  output  1  one-cycle pulse: grant dropped without acceptance.

Behaviour:
- Reset (async, immediate):
  - select=0, grant=0, out_valid=0, done=0, timeout=0.
  - Round-robin pointer ptr=0, hold counter=0, state=IDLE.
- States: IDLE, GRANT. Encoding is 1 bit.
- IDLE:
  - Compute eff = req & mask.
  - If eff==0: stay in IDLE; all outputs hold their reset-idle values, select keeps its last value.
  - Otherwise: pick the first set bit of eff searching ptr, ptr+1, ... 15, 0, ... ptr-1.
  - On the next edge: select=winner, grant=1<<winner, out_valid=1, cnt=0, state=GRANT.
  - Latency: request visible in cycle N, so grant and out_valid are asserted in cycle N+1.
- GRANT:
  - select and grant are frozen.
  - req and mask changes are ignored; the grant is never retracted early, even if the requester drops req.
  - If out_ready=1:
    - Next cycle: done=1, out_valid=0, grant=0, state=IDLE.
    - ptr = select+1, mod 16, so 15 wraps to 0.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1:
    - Next cycle: timeout=1, out_valid=0, grant=0, state=IDLE.
    - ptr = select+1, mod 16.
  - Else: cnt increments by 1; stay in GRANT.
  - If out_ready and the timeout condition occur in the same cycle, out_ready wins: done=1, timeout=0.
- Throughput:
  - One bubble cycle in IDLE after every grant.
  - Maximum rate is one transfer per 2 cycles; the re-arbitration happens in that IDLE cycle.
- Fairness:
  - A channel that was just served has the lowest priority in the next arbitration.
  - With all 16 channels requesting continuously, grants rotate 0,1,...,15,0.
- Reset asserted mid-GRANT: all outputs clear asynchronously; no done or timeout pulse is generated.
- done and timeout are never high in the same cycle. done, timeout and out_valid are mutually exclusive across the same edge.

Decomposition:
- Shared package:
  - N_CH=16 and SEL_W=4 constants.
  - State encodings ST_IDLE=0, ST_GRANT=1.
- Sub-module rr_pick16 (combinational):
  - Inputs: eff[15:0], ptr[3:0].
  - Outputs: any, idx[3:0].
  - Implementation: rotate right by ptr, priority-encode the lowest set bit, add ptr back mod 16.
- The scheduler instantiates one rr_pick16 and holds the FSM, pointer, counter and output registers.
- The mux16_1 datapath is instantiated by the parent with its select input tied to the scheduler's select output.

Test Plan:
- Reset check: assert rst mid-GRANT with select=5.
  - Response: outputs go to 0 immediately, no done pulse.
  - After release with req=0: stays idle.
- Single request: req=16'h0020, mask=16'hFFFF, out_ready=1 from cycle 2.
  - Response: cycle 1 select=5, grant=16'h0020, out_valid=1.
  - Cycle 2 edge: done=1, out_valid=0, ptr=6.
- Rotation and wrap: req=16'hFFFF held, out_ready=1 constant, 40 cycles.
  - Response: select sequence 0,1,...,15,0,1,...
  - One grant every 2 cycles; 15 followed by 0.
- Fairness after service: ptr=6, req=16'h8041.
  - Response: grant order 6, 15, 0, 6.
  - Masking: mask=16'h7FFF removes 15, giving order 6, 0, 6.
- Timeout: TIMEOUT=4, req=16'h0008, out_ready=0.
  - Response: out_valid high for exactly 4 cycles, then timeout=1 for one cycle, ptr=4.
  - Re-grant of channel 3 follows one IDLE cycle later.
- Simultaneous events:
  - TIMEOUT=4 with out_ready=1 exactly in the 4th GRANT cycle: done=1, timeout=0.
  - Requester drops req during GRANT: grant held until out_ready.
